led_pwm_fader: RTL and testbench
================================

Name: led_pwm_fader

Overview:
- Downstream consumer of led_test's `led` output.
- Turns the hard on/off LED level into a smooth fade-in/fade-out PWM drive for the board LED pin.
- Sits between led_test and the top-level LED pad; runs in the same clock domain as led_test, so no synchroniser is needed.

Parameters:
- PWM_BITS, 8, width of the PWM counter and duty register; MAX = 2^PWM_BITS-1.
- STEP_DIV, 4, number of full PWM periods per single duty step (range 1..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- led_in  in  1  target LED level from led_test (1 = on); synchronous to clk.
- enable  in  1  1 = run; 0 = freeze FSM/counters and force pwm_out low.
- pwm_out  out  1  registered PWM drive to the LED pad.
- duty_o  out  PWM_BITS  current duty register, linear value before any gamma.
- busy  out  1  1 while ramping (state UP or DOWN).

Behaviour:
- Reset (rst=1 at a clk edge): state=OFF, pwm_cnt=0, step_cnt=0, duty=0, pwm_out=0, busy=0. Reset mid-ramp aborts immediately to these values.
- PWM counter:
  - pwm_cnt increments every enabled cycle and wraps MAX->0.
  - wrap = (pwm_cnt==MAX).
- Step tick:
  - On each wrap, step_cnt increments.
  - tick = wrap && step_cnt==STEP_DIV-1; step_cnt returns to 0 on tick.
  - With STEP_DIV=1, every wrap is a tick.
- FSM states OFF, UP, ON, DOWN; led_in is evaluated every enabled cycle as a level:
  - OFF: duty=0. led_in=1 -> UP.
  - UP: on tick, duty+1; if duty becomes MAX, go to ON. led_in=0 -> DOWN with no duty change that cycle; the ramp reverses from the current duty.
  - ON: duty=MAX. led_in=0 -> DOWN.
  - DOWN: on tick, duty-1; if duty becomes 0, go to OFF. led_in=1 -> UP, reversing from the current duty.
  - Simultaneous tick and led_in reversal: the reversal wins; no step is taken that cycle.
- Duty timing:
  - duty changes only in the cycle after a tick, i.e. aligned to pwm_cnt=0 of the next period, so there are no mid-period glitches.
  - duty saturates: never wraps below 0 or above MAX.
- Output:
  - pwm_out <= enable && (duty==MAX || pwm_cnt < duty_eff); this is 1 cycle latency from pwm_cnt.
  - duty=0 gives a constant 0; duty=MAX gives a constant 1.
- Ramp length: a full ramp takes MAX*STEP_DIV*2^PWM_BITS cycles; defaults give 261120.
- enable=0:
  - pwm_cnt, step_cnt, duty and state all hold.
  - pwm_out=0 from the next edge.
  - On re-enable, operation resumes exactly where it stopped.
- busy = (state==UP || state==DOWN), registered together with state.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty_eff = (duty*duty) >> PWM_BITS. This is a 2*PWM_BITS-bit product, truncated. duty==MAX still forces full-on.
- Undefined: duty_eff = duty (linear).
- duty_o is the linear duty in both builds.

Decomposition:
- Package led_pkg:
  - fader_state_t enum (OFF, UP, ON, DOWN).
  - Default constants LED_PWM_BITS=8 and LED_STEP_DIV=4, shared with led_test and the top level.
- Sub-module led_pwm_gen (PWM_BITS):
  - Contains the pwm_cnt counter, wrap output, comparator and the registered pwm_out.
  - Inputs: clk, rst, enable, duty_eff, full_on.
- The fader top holds the FSM, step divider and duty register.

Test Plan (PWM_BITS=4, STEP_DIV=2: MAX=15, one step = 32 cycles):
- Reset, then hold led_in=0 for 100 cycles -> pwm_out=0, duty_o=0, busy=0 throughout.
- led_in=1 held -> busy=1 from the next cycle; duty_o reaches 1 after 32 cycles and 15 after 480; state ON, busy=0; pwm_out then constantly 1.
- In ON, drive led_in=0 -> duty_o decrements every 32 cycles and reaches 0 after 480; busy=0; pwm_out constantly 0.
- Raise led_in to 1, then drop it to 0 at duty_o=6 -> duty_o steps 6,5,...,0 with no overshoot; DOWN->OFF.
- At duty_o=4 (linear build), check one PWM period -> pwm_out high for exactly 4 of 16 cycles. Gamma build at duty_o=8 -> high for exactly 4 of 16 cycles.
- Mid-ramp, pulse enable=0 for 50 cycles, then assert rst for 1 cycle mid-ramp:
  - During enable=0: pwm_out=0, and duty_o and pwm_cnt hold, resuming exactly afterwards.
  - After rst: all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/led_pkg.sv
// Shared LED fader types and default sizing, also used by led_test and the top level.
// Latency: n/a (types and constants only). Flow control: n/a.
package led_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    UP   = 2'd1,
    ON   = 2'd2,
    DOWN = 2'd3
  } fader_state_t;

  localparam int LED_PWM_BITS = 8;
  localparam int LED_STEP_DIV = 4;

endpackage

// File: rtl/led_pwm_gen.sv
// PWM counter and comparator; wrap flags the last count of each period.
// Latency: pwm_out is registered one cycle after the pwm_cnt it compares; enable=0 holds pwm_cnt and drives pwm_out low.
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty_eff,
  input  logic                full_on,
  output logic                wrap,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;

  assign wrap = (pwm_cnt == MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      // full_on covers duty==MAX, which the strict compare can never reach
      pwm_out <= enable && (full_on || (pwm_cnt < duty_eff));
      if (enable) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// Fades the on/off LED level into a ramped PWM drive; LED_FADE_GAMMA_EN selects a squared duty curve.
// Latency: pwm_out 1 cycle after pwm_cnt; duty moves one step per STEP_DIV PWM periods.
// Flow control: none; enable=0 freezes FSM, counters and duty and forces pwm_out low.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS,
  parameter int STEP_DIV = LED_STEP_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);
  localparam logic [7:0]          STEP_LAST = 8'(STEP_DIV - 1);

  fader_state_t        state;
  logic [7:0]          step_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_eff;
  logic                wrap;
  logic                tick;

  assign tick   = wrap && (step_cnt == STEP_LAST);
  assign duty_o = duty;

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_wide;
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_wide = {{PWM_BITS{1'b0}}, duty};
  assign duty_sq   = duty_wide * duty_wide;
  assign duty_eff  = PWM_BITS'(duty_sq >> PWM_BITS);
`else
  assign duty_eff = duty;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      step_cnt <= '0;
      duty     <= '0;
      busy     <= 1'b0;
    end else if (enable) begin
      if (wrap) step_cnt <= tick ? 8'd0 : step_cnt + 8'd1;
      // A level reversal takes priority over a step in the same cycle
      case (state)
        OFF: begin
          if (led_in) begin
            state <= UP;
            busy  <= 1'b1;
          end
        end
        UP: begin
          if (!led_in) begin
            state <= DOWN;
          end else if (tick) begin
            if (duty != MAX) duty <= duty + ONE;
            if (duty >= MAX - ONE) begin
              state <= ON;
              busy  <= 1'b0;
            end
          end
        end
        ON: begin
          if (!led_in) begin
            state <= DOWN;
            busy  <= 1'b1;
          end
        end
        DOWN: begin
          if (led_in) begin
            state <= UP;
          end else if (tick) begin
            if (duty != '0) duty <= duty - ONE;
            if (duty <= ONE) begin
              state <= OFF;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= OFF;
      endcase
    end
  end

  led_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .duty_eff (duty_eff),
    .full_on  (duty == MAX),
    .wrap     (wrap),
    .pwm_out  (pwm_out)
  );

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader at PWM_BITS=4, STEP_DIV=2 against a ramp model driven by the enabled-cycle count.
module tb_led_pwm_fader;

  localparam int PB  = 4;
  localparam int SD  = 2;
  localparam int MX  = (1 << PB) - 1;
  localparam int PER = MX + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          led_in;
  logic          enable;
  logic          pwm_out;
  logic [PB-1:0] duty_o;
  logic          busy;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .PWM_BITS(PB),
    .STEP_DIV(SD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led_in  (led_in),
    .enable  (enable),
    .pwm_out (pwm_out),
    .duty_o  (duty_o),
    .busy    (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Model: enabled cycles since reset give the PWM position; a step falls on the
  // last cycle of every SD-th period. Ramp is tracked as busy + direction.
  int m_phase;
  int m_duty;
  bit m_busy;
  bit m_up;
  bit m_pwm;

  function automatic int eff(input int d);
`ifdef LED_FADE_GAMMA_EN
    return (d * d) >> PB;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin : model
    bit nxt_pwm;
    bit tick;
    if (rst) begin
      m_phase = 0;
      m_duty  = 0;
      m_busy  = 1'b0;
      m_up    = 1'b0;
      m_pwm   = 1'b0;
    end else begin
      nxt_pwm = enable && (m_duty == MX || (m_phase % PER) < eff(m_duty));
      if (enable) begin
        tick = (m_phase % (PER * SD)) == (PER * SD - 1);
        if (!m_busy) begin
          if (led_in && m_duty == 0) begin
            m_busy = 1'b1;
            m_up   = 1'b1;
          end else if (!led_in && m_duty == MX) begin
            m_busy = 1'b1;
            m_up   = 1'b0;
          end
        end else if (led_in != m_up) begin
          m_up = led_in;
        end else if (tick) begin
          if (m_up) m_duty = (m_duty < MX) ? m_duty + 1 : MX;
          else      m_duty = (m_duty > 0)  ? m_duty - 1 : 0;
          if (m_duty == 0 || m_duty == MX) m_busy = 1'b0;
        end
        m_phase++;
      end
      m_pwm = nxt_pwm;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pwm_out", int'(pwm_out), int'(m_pwm));
      chk("duty_o",  int'(duty_o),  m_duty);
      chk("busy",    int'(busy),    int'(m_busy));
    end
  end

  task automatic wait_duty(input int target, input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      step(1);
      if (int'(duty_o) == target) found = 1'b1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_duty: duty_o never reached %0d within %0d cycles", target, limit);
    end
  endtask

  initial begin
    int peak;
    int hi;
    int d0;
    int tgt;
    bit idle;
    rst    = 1'b1;
    led_in = 1'b0;
    enable = 1'b1;
    step(2);
    chk("rst_pwm",  int'(pwm_out), 0);
    chk("rst_duty", int'(duty_o),  0);
    chk("rst_busy", int'(busy),    0);
    rst    = 1'b0;
    chk_on = 1'b1;

    step(100);
    chk("idle_duty", int'(duty_o),  0);
    chk("idle_busy", int'(busy),    0);
    chk("idle_pwm",  int'(pwm_out), 0);

    // Raised at enabled-cycle 100: first step at cycle 127, last at 575
    led_in = 1'b1;
    step(1);
    chk("up_busy", int'(busy), 1);
    step(26);
    chk("up_duty_pre1", int'(duty_o), 0);
    step(1);
    chk("up_duty_1", int'(duty_o), 1);
    step(448);
    chk("up_duty_max", int'(duty_o), 15);
    chk("on_busy",     int'(busy),   0);
    step(2);
    chk("on_pwm", int'(pwm_out), 1);

    led_in = 1'b0;
    step(520);
    chk("down_duty", int'(duty_o),  0);
    chk("down_busy", int'(busy),    0);
    chk("down_pwm",  int'(pwm_out), 0);

    led_in = 1'b1;
    wait_duty(6, 400);
    led_in = 1'b0;
    peak = int'(duty_o);
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      step(1);
      if (int'(duty_o) > peak) peak = int'(duty_o);
      if (!busy) idle = 1'b1;
    end
    chk("rev_peak", peak, 6);
    chk("rev_duty", int'(duty_o), 0);
    chk("rev_idle", int'(idle), 1);

`ifdef LED_FADE_GAMMA_EN
    tgt = 8;
`else
    tgt = 4;
`endif
    led_in = 1'b1;
    wait_duty(tgt, 600);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      step(1);
      hi += int'(pwm_out);
    end
    chk("period_high", hi, 4);

    step(5);
    d0 = int'(duty_o);
    enable = 1'b0;
    step(50);
    chk("hold_duty", int'(duty_o),  d0);
    chk("hold_pwm",  int'(pwm_out), 0);
    enable = 1'b1;
    step(40);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_duty", int'(duty_o),  0);
    chk("midrst_busy", int'(busy),    0);
    chk("midrst_pwm",  int'(pwm_out), 0);
    step(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
